// File: rtl/lfsr_prng_core.sv
// Fibonacci LFSR pseudorandom generator stepped by a one-cycle tick strobe, with seed load,
// start/stop control and zero-lockup recovery. Define LFSR_PERIOD_CHECK_EN for period_done.
module lfsr_prng_core #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] rnd,
    output logic             valid,
    output logic             running,
    output logic             lockup_err,
    output logic             period_done
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rnd_q, rnd_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             lock_q, lock_d;
    logic             valid_q, valid_d;
    logic             do_step;
    logic             do_start;
    logic             fb;
    logic [WIDTH-1:0] step_val;

    // Priority load > stop > start > tick: each lower input acts only when all higher are low.
    assign do_start = !load && !stop && start;
    assign do_step  = !load && !stop && !start && tick && (state_q == StRun);

    assign fb       = ^(rnd_q & TAPS);
    // An all-zero state would lock the LFSR, so that step recovers to SEED instead.
    assign step_val = (rnd_q == '0) ? SEED : {rnd_q[WIDTH-2:0], fb};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!load) begin
            if (stop) begin
                state_d = StIdle;
            end else if (start) begin
                state_d = StRun;
            end
        end
    end

    always_comb begin
        running = (state_q == StRun);
    end

    always_comb begin
        rnd_d   = rnd_q;
        ref_d   = ref_q;
        lock_d  = lock_q;
        valid_d = 1'b0;
        if (load) begin
            if (seed_in != '0) begin
                rnd_d  = seed_in;
                ref_d  = seed_in;
                lock_d = 1'b0;
            end else begin
                rnd_d  = SEED;
                ref_d  = SEED;
                lock_d = 1'b1;
            end
        end else if (do_start) begin
            ref_d = rnd_q;
        end else if (do_step) begin
            rnd_d   = step_val;
            valid_d = 1'b1;
            if (rnd_q == '0) begin
                lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q   <= SEED;
            ref_q   <= SEED;
            lock_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rnd_q   <= rnd_d;
            ref_q   <= ref_d;
            lock_q  <= lock_d;
            valid_q <= valid_d;
        end
    end

    assign rnd        = rnd_q;
    assign valid      = valid_q;
    assign lockup_err = lock_q;

`ifdef LFSR_PERIOD_CHECK_EN
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             pd_q, pd_d;

    always_comb begin
        cnt_d = cnt_q;
        pd_d  = 1'b0;
        if (load || do_start) begin
            cnt_d = '0;
        end else if (do_step) begin
            if (step_val == ref_q) begin
                pd_d  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            pd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pd_q  <= pd_d;
        end
    end

    assign period_done = pd_q;
`else
    assign period_done = 1'b0;
`endif

endmodule
